register_bank_dbg: RTL and testbench
====================================

// Module: register_bank_dbg
// PURPOSE
//  Parametrised MIPS general-purpose register bank: two async read ports (rs, rt), one sync write port (rd).
//  Optional write-to-read bypass and hardwired-zero register.
//  Adds a debug dump sequencer that streams every register, in address order, to the debug unit (UART path)
//  over a valid/ready handshake. Sits in the ID stage; the dump port is driven by the debug unit.
// PARAMETERS
//  NB_DATA   32  register width in bits
//  NB_ADDR   5   address width; register count N_REGS = 2**NB_ADDR (localparam)
//  ZERO_REG  1   1: register 0 reads 0, writes to it are discarded; 0: register 0 is an ordinary register
//  BYPASS    1   1: a read of the register being written this cycle returns i_data_rd; 0: returns the stored value
// PORTS
//  clk            in   1        clock; all state updates on rising edge
//  rst            in   1        asynchronous, active-low reset
//  i_wenable      in   1        write enable for rd port
//  i_addres_rs    in   NB_ADDR  read address, port rs
//  i_addres_rt    in   NB_ADDR  read address, port rt
//  i_addres_rd    in   NB_ADDR  write address
//  i_data_rd      in   NB_DATA  write data
//  o_data_rs      out  NB_DATA  read data, port rs (combinational)
//  o_data_rt      out  NB_DATA  read data, port rt (combinational)
//  i_dump_start   in   1        1-cycle request to start a dump; ignored while o_dump_busy=1
//  i_dump_ready   in   1        debug unit accepts the current beat
//  o_dump_valid   out  1        current beat valid
//  o_dump_addr    out  NB_ADDR  register index of the current beat
//  o_dump_data    out  NB_DATA  register contents of the current beat (registered)
//  o_dump_busy    out  1        sequencer not IDLE
//  o_dump_done    out  1        1-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  Reset (rst=0, async): all N_REGS registers cleared to 0. FSM=IDLE. o_dump_valid/busy/done=0, o_dump_addr=0,
//    o_dump_data=0. o_data_rs/rt therefore read 0.
//  Write: on posedge when i_wenable=1, mem[i_addres_rd] <= i_data_rd. If ZERO_REG=1 and addr=0, no write.
//  Read: o_data_X = (ZERO_REG && addr==0) ? 0 :
//    (BYPASS && i_wenable && addr==i_addres_rd) ? i_data_rd : mem[addr]. Zero-register check overrides bypass.
//  Both read ports may address the same register; both then return the same value.
//  FSM states:
//    IDLE: on i_dump_start -> DUMP; load idx=0, o_dump_data <= mem[0] as stored before this edge's write.
//    DUMP: o_dump_valid=1. On valid&&ready: if idx==N_REGS-1 -> DONE; else idx+1 and o_dump_data <= mem[idx+1]
//          (pre-write value). Without ready, addr/data held stable regardless of writes.
//    DONE: o_dump_done=1 for exactly one cycle -> IDLE. A start in this cycle is ignored.
//  o_dump_busy=1 in DUMP and DONE. A dump takes exactly N_REGS+1 cycles with ready held at 1.
//  Normal reads and writes continue during a dump. A beat reflects contents at its capture edge.
//  With ZERO_REG=1, beat 0 carries 0.
//  idx never wraps: the sequencer stops at N_REGS-1.
//  Reset mid-dump: immediate abort to IDLE with all outputs at reset values. No done pulse.
// STRUCTURE
//  Shared package regbank_pkg: dump FSM state encoding (IDLE=2'd0, DUMP=2'd1, DONE=2'd2);
//    default NB_DATA/NB_ADDR constants.
//  One sub-module: regbank_dump_seq (FSM + idx counter + data capture register).
//    It reads the storage array through an address/data pair.
//  Storage array and read/bypass muxes stay in register_bank_dbg.
// TESTING (default params)
//  1 Hold rst=0, then release. Read rs=3, rt=31 -> both 0. All dump outputs at 0.
//  2 Write r3=0xFF010000, then r1=0xFF010011 on consecutive cycles, then wenable=0.
//    rs=1, rt=0 -> 0xFF010011, 0. rs=0, rt=3 -> 0, 0xFF010000.
//  3 Bypass: wenable=1, rd=7, data=0xDEADBEEF, rs=7 in the same cycle -> o_data_rs=0xDEADBEEF before the edge.
//    Same with rd=0 -> rs=0 reads 0, r0 stays 0.
//    BYPASS=0 instance -> old r7 value until the edge.
//  4 Load r[i]=i*0x11111111, pulse start, ready=1 -> 32 beats in addr 0..31 with matching data.
//    Done pulse in cycle 33, busy low after. Start pulses mid-dump have no effect.
//  5 Dump with ready toggling 1/0 while r[addr+1] is written during a stall.
//    Stalled beat holds addr/data. The next beat carries the new value.
//  6 Assert rst at beat 10 -> valid/busy drop asynchronously, no done pulse, all registers read 0.
//    New start restarts at addr 0.

Source files
------------

// File: rtl/regbank_pkg.sv
// regbank_pkg: shared dump FSM state encoding and default register bank sizes
package regbank_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DUMP = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam int NB_DATA_DEF = 32;
    localparam int NB_ADDR_DEF = 5;
endpackage

// File: rtl/regbank_dump_seq.sv
// regbank_dump_seq: streams every register in address order over a valid/ready handshake
module regbank_dump_seq
    import regbank_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_dump_start,
    input  logic               i_dump_ready,
    output logic [NB_ADDR-1:0] o_rd_addr,
    input  logic [NB_DATA-1:0] i_rd_data,
    output logic               o_dump_valid,
    output logic [NB_ADDR-1:0] o_dump_addr,
    output logic [NB_DATA-1:0] o_dump_data,
    output logic               o_dump_busy,
    output logic               o_dump_done
);
    logic [1:0]         state;
    logic [NB_ADDR-1:0] idx;

    // Storage is looked up at the address of the beat about to be captured
    assign o_rd_addr    = (state == ST_IDLE) ? '0 : idx + 1'b1;
    assign o_dump_valid = state == ST_DUMP;
    assign o_dump_busy  = state != ST_IDLE;
    assign o_dump_done  = state == ST_DONE;
    assign o_dump_addr  = idx;

    // Dump FSM: capture beat 0 on start, advance on each accepted beat, stop at the last register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            o_dump_data <= '0;
        end else begin
            case (state)
                ST_IDLE: if (i_dump_start) begin
                    state       <= ST_DUMP;
                    idx         <= '0;
                    o_dump_data <= i_rd_data;
                end
                ST_DUMP: if (i_dump_ready) begin
                    if (&idx) begin
                        state <= ST_DONE;
                    end else begin
                        idx         <= idx + 1'b1;
                        o_dump_data <= i_rd_data;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/register_bank_dbg.sv
// register_bank_dbg: MIPS register bank with 2 async reads, 1 sync write, bypass and debug dump port
module register_bank_dbg
    import regbank_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int NB_ADDR  = NB_ADDR_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_wenable,
    input  logic [NB_ADDR-1:0] i_addres_rs,
    input  logic [NB_ADDR-1:0] i_addres_rt,
    input  logic [NB_ADDR-1:0] i_addres_rd,
    input  logic [NB_DATA-1:0] i_data_rd,
    output logic [NB_DATA-1:0] o_data_rs,
    output logic [NB_DATA-1:0] o_data_rt,
    input  logic               i_dump_start,
    input  logic               i_dump_ready,
    output logic               o_dump_valid,
    output logic [NB_ADDR-1:0] o_dump_addr,
    output logic [NB_DATA-1:0] o_dump_data,
    output logic               o_dump_busy,
    output logic               o_dump_done
);
    localparam int N_REGS = 2 ** NB_ADDR;

    logic [NB_DATA-1:0] mem [N_REGS];
    logic [NB_ADDR-1:0] seq_addr;

    // Zero register wins over bypass; bypass forwards the data being written this cycle
    function automatic logic [NB_DATA-1:0] read_port(input logic [NB_ADDR-1:0] a);
        return (ZERO_REG != 0 && a == '0) ? '0 :
               (BYPASS != 0 && i_wenable && a == i_addres_rd) ? i_data_rd : mem[a];
    endfunction

    assign o_data_rs = read_port(i_addres_rs);
    assign o_data_rt = read_port(i_addres_rt);

    // Storage: cleared on reset, writes to register 0 dropped when it is hardwired
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REGS; i++) mem[i] <= '0;
        end else if (i_wenable && !(ZERO_REG != 0 && i_addres_rd == '0)) begin
            mem[i_addres_rd] <= i_data_rd;
        end
    end

    regbank_dump_seq #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) u_seq (
        .clk          (clk),
        .rst          (rst),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .o_rd_addr    (seq_addr),
        .i_rd_data    (mem[seq_addr]),
        .o_dump_valid (o_dump_valid),
        .o_dump_addr  (o_dump_addr),
        .o_dump_data  (o_dump_data),
        .o_dump_busy  (o_dump_busy),
        .o_dump_done  (o_dump_done)
    );
endmodule

// File: tb/tb_register_bank_dbg.sv
// tb_register_bank_dbg: randomized scoreboard bench for the register bank and its dump port
module tb_register_bank_dbg;
    logic        clk = 0;
    logic        rst = 0;
    logic        wen = 0;
    logic [4:0]  rs = 0, rt = 0, rd = 0;
    logic [31:0] wdata = 0;
    logic        start = 0, ready = 0;
    logic [31:0] rs_d, rt_d, ddata, nb_rs, nb_rt, nb_ddata;
    logic [4:0]  daddr, nb_daddr;
    logic        valid, busy, done, nb_valid, nb_busy, nb_done;

    typedef struct { logic [4:0] a; logic [31:0] d; } beat_t;
    beat_t       q[$];
    logic [31:0] m_mem[32];
    logic [31:0] m_nb[32];
    int          m_st = 0;
    int          m_beat = 0;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    register_bank_dbg dut (
        .clk(clk), .rst(rst), .i_wenable(wen), .i_addres_rs(rs), .i_addres_rt(rt),
        .i_addres_rd(rd), .i_data_rd(wdata), .o_data_rs(rs_d), .o_data_rt(rt_d),
        .i_dump_start(start), .i_dump_ready(ready), .o_dump_valid(valid), .o_dump_addr(daddr),
        .o_dump_data(ddata), .o_dump_busy(busy), .o_dump_done(done)
    );

    register_bank_dbg #(.ZERO_REG(0), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .i_wenable(wen), .i_addres_rs(rs), .i_addres_rt(rt),
        .i_addres_rd(rd), .i_data_rd(wdata), .o_data_rs(nb_rs), .o_data_rt(nb_rt),
        .i_dump_start(1'b0), .i_dump_ready(1'b0), .o_dump_valid(nb_valid), .o_dump_addr(nb_daddr),
        .o_dump_data(nb_ddata), .o_dump_busy(nb_busy), .o_dump_done(nb_done)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        return (a == 0) ? 32'h0 : (wen && rd == a) ? wdata : m_mem[a];
    endfunction

    // Mid-cycle checks of the combinational view, then advance the model across the next edge
    task automatic step();
        #2;
        chk("rs", rs_d, exp_rd(rs));
        chk("rt", rt_d, exp_rd(rt));
        chk("nb rs", nb_rs, m_nb[rs]);
        chk("nb rt", nb_rt, m_nb[rt]);
        chk("valid", {31'b0, valid}, {31'b0, m_st == 1});
        chk("busy", {31'b0, busy}, {31'b0, m_st != 0});
        chk("done", {31'b0, done}, {31'b0, m_st == 2});
        if (rst) begin
            if (m_st == 0) begin
                if (start) begin
                    q.push_back('{5'd0, m_mem[0]});
                    m_st = 1;
                    m_beat = 0;
                end
            end else if (m_st == 1) begin
                if (ready) begin
                    if (m_beat == 31) m_st = 2;
                    else begin
                        m_beat++;
                        q.push_back('{5'(m_beat), m_mem[m_beat]});
                    end
                end
            end else m_st = 0;
            if (wen) begin
                if (rd != 0) m_mem[rd] = wdata;
                m_nb[rd] = wdata;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 0;
        wen = 0;
        start = 0;
        #1;
        chk("rst valid", {31'b0, valid}, 0);
        chk("rst busy", {31'b0, busy}, 0);
        chk("rst done", {31'b0, done}, 0);
        chk("rst daddr", {27'b0, daddr}, 0);
        chk("rst ddata", ddata, 0);
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 0;
            m_nb[i] = 0;
        end
        m_st = 0;
        q.delete();
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i);
            rt = 5'(31 - i);
            #1;
            chk("rst rs", rs_d, 0);
            chk("rst rt", rt_d, 0);
        end
        step();
        rst = 1;
    endtask

    // Scoreboard monitor: every presented beat must match the head of the expected queue
    always @(negedge clk) begin
        if (rst && valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL beat: unexpected beat addr %0d data %h", daddr, ddata);
            end else begin
                chk("beat addr", {27'b0, daddr}, {27'b0, q[0].a});
                chk("beat data", ddata, q[0].d);
                if (ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        int k;
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 0;
            m_nb[i] = 0;
        end
        // 1: reset state
        repeat (3) @(posedge clk);
        rs = 3;
        rt = 31;
        #1;
        chk("t1 rs", rs_d, 0);
        chk("t1 rt", rt_d, 0);
        chk("t1 valid", {31'b0, valid}, 0);
        chk("t1 busy", {31'b0, busy}, 0);
        chk("t1 done", {31'b0, done}, 0);
        chk("t1 daddr", {27'b0, daddr}, 0);
        chk("t1 ddata", ddata, 0);
        rst = 1;
        step();
        // 2: writes then reads
        wen = 1; rd = 3; wdata = 32'hFF010000; step();
        rd = 1; wdata = 32'hFF010011; step();
        wen = 0; rs = 1; rt = 0; #1;
        chk("t2 rs1", rs_d, 32'hFF010011);
        chk("t2 rt0", rt_d, 0);
        step();
        rs = 0; rt = 3; #1;
        chk("t2 rs0", rs_d, 0);
        chk("t2 rt3", rt_d, 32'hFF010000);
        step();
        // 3: bypass, zero register, no-bypass instance
        wen = 1; rd = 7; wdata = 32'hDEADBEEF; rs = 7; rt = 7; #1;
        chk("t3 byp", rs_d, 32'hDEADBEEF);
        chk("t3 nobyp", nb_rs, 0);
        step();
        rd = 0; rs = 0; wdata = 32'h12345678; #1;
        chk("t3 r0 byp", rs_d, 0);
        chk("t3 nb r0 old", nb_rs, 0);
        step();
        wen = 0; #1;
        chk("t3 r0 kept", rs_d, 0);
        chk("t3 nb r0 new", nb_rs, 32'h12345678);
        chk("t3 r7", rt_d, 32'hDEADBEEF);
        step();
        // 4: full dump with ready held, spurious starts
        for (int i = 0; i < 32; i++) begin
            wen = 1; rd = 5'(i); wdata = i * 32'h11111111; step();
        end
        wen = 0; start = 1; ready = 1; step();
        k = 1;
        while (!done && k < 60) begin
            start = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        chk("t4 dump len", k, 33);
        start = 0; step();
        chk("t4 busy after", {31'b0, busy}, 0);
        // 5: ready toggling, next register written during a stall
        start = 1; ready = 0; step(); start = 0;
        k = 0;
        while (m_st != 0 && k < 200) begin
            ready = ~ready;
            if (!ready && m_st == 1 && m_beat < 31) begin
                wen = 1; rd = 5'(m_beat + 1); wdata = $urandom;
            end else wen = 0;
            step();
            k++;
        end
        wen = 0;
        chk("t5 finished", m_st, 0);
        // 6: reset mid-dump, then restart from address 0
        start = 1; ready = 1; step(); start = 0;
        k = 0;
        while (m_beat < 10 && m_st == 1 && k < 50) begin step(); k++; end
        do_reset();
        chk("t6 no done", {31'b0, done}, 0);
        start = 1; step(); start = 0;
        k = 0;
        while (m_st != 0 && k < 60) begin step(); k++; end
        chk("t6 finished", m_st, 0);
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            wen = 1'($urandom_range(0, 1));
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
            wdata = $urandom;
            start = ($urandom_range(0, 15) == 0);
            ready = 1'($urandom_range(0, 1));
            step();
        end
        wen = 0; start = 0; ready = 1;
        k = 0;
        while (m_st != 0 && k < 100) begin step(); k++; end
        step();
        chk("drain idle", m_st, 0);
        chk("queue empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
